gcd_result_bcd: RTL and testbench
=================================

// Module: gcd_result_bcd
// PURPOSE
//   Downstream consumer of the GCD core. Captures result and ERROR on the rising edge
//   of GCD done and converts the binary result to packed BCD by sequential double-dabble
//   (one bit per clock). Holds the digits for the display/scan stage that follows.
//   Forwards the GCD error condition in place of a number.
// PARAMETERS
//   WIDTH   32  binary input width; must equal the GCD result width
//   DIGITS  10  BCD digits produced; 10^DIGITS > 2^WIDTH-1 required (32 -> 10)
// PORTS
//   clk          in   1           single system clock, rising edge
//   rst          in   1           asynchronous, active-low reset
//   done         in   1           GCD done; level, may stay high several cycles
//   result       in   WIDTH       GCD result; sampled only on the rising edge of done
//   ERROR        in   1           GCD error flag; sampled with result
//   bcd          out  4*DIGITS    packed BCD, digit 0 (units) in bcd[3:0]
//   busy         out  1           conversion in progress
//   valid        out  1           bcd/err_out hold a completed capture (level)
//   valid_pulse  out  1           one-cycle strobe when valid rises or is refreshed
//   err_out      out  1           captured ERROR
//   blank        out  DIGITS      per-digit leading-zero blank mask (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; bcd=0, busy=0, valid=0, valid_pulse=0, err_out=0,
//     blank=0, done_d=0, iteration count=0. Reset mid-conversion aborts; no output survives.
//   Edge detect: done_d <= done each clock; capture = done & ~done_d. Held done = one capture.
//   States: IDLE, CONV. DONE is represented by IDLE with valid=1.
//   Capture edge T0, ERROR=0: shift reg <= result, BCD accum <= 0, cnt <= 0, busy=1,
//     valid=0, state CONV. bcd output unchanged until completion.
//   CONV, each clock: every BCD digit >=5 gets +3, then {accum,shift} shifted left 1; cnt++.
//     Corrections use the pre-shift digit value; all digits corrected in the same cycle.
//   Completion: on the WIDTH-th CONV edge (T0+WIDTH) bcd <= final accum, err_out=0,
//     valid=1, valid_pulse=1 for that one cycle, busy=0, state IDLE.
//     Latency: valid visible WIDTH clocks after the capture edge (32 for default).
//   Capture edge T0, ERROR=1: no conversion; at T0 bcd <= all digits 4'hF, err_out=1,
//     valid=1, valid_pulse=1, busy=0. Latency 1 edge.
//   New capture while CONV: latest wins. Current conversion abandoned, new operand
//     loaded at that edge, cnt restarts; no valid_pulse for the abandoned one.
//   Capture in IDLE with valid=1: valid drops at the capture edge (non-error path) and
//     re-rises at completion; previous bcd stays on the port until overwritten.
//   result=0 converts normally -> bcd all zero after WIDTH cycles.
//   Width rules: accum is 4*DIGITS bits; no overflow possible given parameter constraint.
// CONFIGURATION
//   GCD_BCD_BLANK_EN defined: blank[i]=1 when digit i and all higher digits are 0,
//     for i>=1; blank[0] always 0 (a zero shows as "0"). Updated together with bcd.
//     When err_out=1, blank = all 0.
//   Not defined: blank tied to all 0; no blanking logic synthesised.
// TESTING
//   Reset: rst=0 mid-run -> all outputs 0 immediately, async; release -> IDLE, valid=0.
//   result=3, ERROR=0, done high 1 cycle -> busy 32 cycles, then bcd=40'h0000000003,
//     valid=1, one valid_pulse, err_out=0.
//   result=32'hFFFFFFFF -> bcd=40'h4294967295; result=0 -> bcd=0, both after 32 cycles.
//   ERROR=1 (GCD given A=0,B=3) -> next edge bcd=40'hFFFFFFFFFF, err_out=1, valid=1, busy=0.
//   done held high 5 cycles -> exactly one conversion, exactly one valid_pulse.
//   result=12 captured, new done edge with result=7 at cycle 10 of CONV -> single
//     valid_pulse 32 cycles after second edge, bcd=40'h0000000007.
//   GCD_BCD_BLANK_EN, result=1200 -> blank=10'b1111110000; undefined -> blank=0.

Source files
------------

// File: rtl/gcd_result_bcd.sv
// Captures the GCD result on the rising edge of done and converts it to packed BCD by
// sequential double-dabble. Optional leading-zero blanking is enabled with GCD_BCD_BLANK_EN.
module gcd_result_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [WIDTH-1:0]      result,
  input  logic                  ERROR,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  valid,
  output logic                  valid_pulse,
  output logic                  err_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_next;
  logic            done_d;
  logic            capture;
  logic            last;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]   accum_q;
  logic [BW-1:0]   accum_corr;
  logic [BW-1:0]   accum_next;
  logic [CW-1:0]   cnt_q;

  assign capture = done & ~done_d;
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign busy    = (state == CONV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A fresh capture always wins: an ERROR capture abandons any conversion in flight.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture && !ERROR) state_next = CONV;
      CONV: begin
        if (capture)   state_next = ERROR ? IDLE : CONV;
        else if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on the pre-shift digits, then shift one operand bit in.
  always_comb begin
    accum_corr = accum_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (accum_q[4*i +: 4] >= 4'd5) accum_corr[4*i +: 4] = accum_q[4*i +: 4] + 4'd3;
    end
    accum_next = {accum_corr[BW-2:0], shift_q[WIDTH-1]};
  end

`ifdef GCD_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              zero_run;

  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (accum_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d      <= 1'b0;
      shift_q     <= '0;
      accum_q     <= '0;
      cnt_q       <= '0;
      bcd         <= '0;
      valid       <= 1'b0;
      valid_pulse <= 1'b0;
      err_out     <= 1'b0;
`ifdef GCD_BCD_BLANK_EN
      blank       <= '0;
`endif
    end else begin
      done_d      <= done;
      valid_pulse <= 1'b0;
      if (capture && ERROR) begin
        bcd         <= '1;
        err_out     <= 1'b1;
        valid       <= 1'b1;
        valid_pulse <= 1'b1;
        cnt_q       <= '0;
`ifdef GCD_BCD_BLANK_EN
        blank       <= '0;
`endif
      end else if (capture) begin
        shift_q <= result;
        accum_q <= '0;
        cnt_q   <= '0;
        valid   <= 1'b0;
      end else if (state == CONV) begin
        accum_q <= accum_next;
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          bcd         <= accum_next;
          err_out     <= 1'b0;
          valid       <= 1'b1;
          valid_pulse <= 1'b1;
`ifdef GCD_BCD_BLANK_EN
          blank       <= blank_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_result_bcd.sv
// Bench for gcd_result_bcd: directed and random captures checked against a decimal
// reference model (repeated division by ten), including restart, held done and reset.
module tb_gcd_result_bcd;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                done = 1'b0;
  logic [WIDTH-1:0]    result = '0;
  logic                ERROR = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                valid;
  logic                valid_pulse;
  logic                err_out;
  logic [DIGITS-1:0]   blank;

  int errors = 0;
  int checks = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  gcd_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .done(done), .result(result), .ERROR(ERROR),
    .bcd(bcd), .busy(busy), .valid(valid), .valid_pulse(valid_pulse),
    .err_out(err_out), .blank(blank)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4*DIGITS-1:0] model_bcd(input logic [WIDTH-1:0] v);
    longint unsigned n = 64'(v);
    logic [4*DIGITS-1:0] o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      o[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return o;
  endfunction

  function automatic logic [DIGITS-1:0] model_blank(input logic [WIDTH-1:0] v);
    logic [DIGITS-1:0] b = '0;
`ifdef GCD_BCD_BLANK_EN
    longint unsigned p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      b[i] = ((64'(v) / p) == 0);
    end
`endif
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [WIDTH-1:0] r, input logic e);
    @(negedge clk);
    result = r;
    ERROR  = e;
    done   = 1'b1;
  endtask

  // lat = negedges after launch until valid_pulse (0 if none within bound)
  task automatic wait_pulse(input int hold, output int lat, output int busy_n,
                            output logic valid_first);
    lat = 0; busy_n = 0; valid_first = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == hold) done = 1'b0;
      if (k == 1) valid_first = valid;
      if (busy) busy_n++;
      if (valid_pulse) begin
        lat = k;
        break;
      end
    end
    done = 1'b0;
  endtask

  task automatic count_pulses(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      done = 1'b0;
      if (valid_pulse) c++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({bcd, busy, valid, valid_pulse, err_out, blank} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bcd=%h busy=%b valid=%b pulse=%b err=%b blank=%b required all zero",
               bcd, busy, valid, valid_pulse, err_out, blank);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b busy=%b required 0 0", valid, busy);
    end
  endtask

  task automatic test_known_values;
    logic [WIDTH-1:0]    ops [4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd1200};
    logic [4*DIGITS-1:0] exps[4] = '{40'h0000000003, 40'h4294967295, 40'h0000000000, 40'h0000001200};
    int lat, busy_n;
    logic vf;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], 1'b0);
      wait_pulse(1, lat, busy_n, vf);
      checks++;
      if (lat !== WIDTH + 1) begin
        errors++;
        $display("FAIL known_latency[%0d]: got %0d required %0d", i, lat, WIDTH + 1);
      end
      checks++;
      if (busy_n !== WIDTH) begin
        errors++;
        $display("FAIL known_busy_cycles[%0d]: got %0d required %0d", i, busy_n, WIDTH);
      end
      checks++;
      if (bcd !== exps[i] || err_out !== 1'b0 || valid !== 1'b1) begin
        errors++;
        $display("FAIL known_bcd[%0d]: got bcd=%h err=%b valid=%b required bcd=%h err=0 valid=1",
                 i, bcd, err_out, valid, exps[i]);
      end
      checks++;
      if (blank !== model_blank(ops[i])) begin
        errors++;
        $display("FAIL known_blank[%0d]: got %b required %b", i, blank, model_blank(ops[i]));
      end
      @(negedge clk);
      checks++;
      if (valid_pulse !== 1'b0 || valid !== 1'b1) begin
        errors++;
        $display("FAIL known_pulse_width[%0d]: got pulse=%b valid=%b required 0 1", i, valid_pulse, valid);
      end
    end
  endtask

  task automatic test_error;
    int lat, busy_n;
    logic vf;
    launch(32'd0, 1'b1);
    wait_pulse(1, lat, busy_n, vf);
    checks++;
    if (lat !== 1 || busy_n !== 0) begin
      errors++;
      $display("FAIL error_latency: got lat=%0d busy_n=%0d required 1 0", lat, busy_n);
    end
    checks++;
    if (bcd !== 40'hFFFFFFFFFF || err_out !== 1'b1 || valid !== 1'b1 || blank !== '0) begin
      errors++;
      $display("FAIL error_outputs: got bcd=%h err=%b valid=%b blank=%b required FFFFFFFFFF 1 1 0",
               bcd, err_out, valid, blank);
    end
    launch(32'd5, 1'b0);
    wait_pulse(1, lat, busy_n, vf);
    checks++;
    if (lat !== WIDTH + 1 || bcd !== model_bcd(32'd5) || err_out !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got lat=%0d bcd=%h err=%b required %0d %h 0",
               lat, bcd, err_out, WIDTH + 1, model_bcd(32'd5));
    end
  endtask

  task automatic test_held_done;
    int lat, busy_n, c;
    logic vf;
    logic [WIDTH-1:0] r = $urandom;
    launch(r, 1'b0);
    wait_pulse(5, lat, busy_n, vf);
    count_pulses(40, c);
    checks++;
    if (lat !== WIDTH + 1 || c !== 0) begin
      errors++;
      $display("FAIL held_done: got lat=%0d extra_pulses=%0d required %0d 0", lat, c, WIDTH + 1);
    end
    checks++;
    if (bcd !== model_bcd(r)) begin
      errors++;
      $display("FAIL held_done_bcd: got %h required %h", bcd, model_bcd(r));
    end
  endtask

  task automatic test_restart;
    int lat, busy_n, c0, c1;
    logic vf;
    launch(32'd12, 1'b0);
    count_pulses(10, c0);
    launch(32'd7, 1'b0);
    wait_pulse(1, lat, busy_n, vf);
    count_pulses(40, c1);
    checks++;
    if (c0 !== 0 || c1 !== 0 || lat !== WIDTH + 1) begin
      errors++;
      $display("FAIL restart_pulses: got early=%0d lat=%0d late=%0d required 0 %0d 0", c0, lat, c1, WIDTH + 1);
    end
    checks++;
    if (bcd !== 40'h0000000007) begin
      errors++;
      $display("FAIL restart_bcd: got %h required 0000000007", bcd);
    end
  endtask

  task automatic test_reset_midrun;
    int lat, busy_n, c;
    logic vf;
    launch(32'd0, 1'b1);
    wait_pulse(1, lat, busy_n, vf);
    launch(32'd99, 1'b0);
    count_pulses(5, c);
    checks++;
    if (busy !== 1'b1 || bcd !== 40'hFFFFFFFFFF || err_out !== 1'b1) begin
      errors++;
      $display("FAIL midrun_before: got busy=%b bcd=%h err=%b required 1 FFFFFFFFFF 1", busy, bcd, err_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bcd, busy, valid, valid_pulse, err_out, blank} !== '0) begin
      errors++;
      $display("FAIL midrun_async_reset: got bcd=%h busy=%b valid=%b pulse=%b err=%b blank=%b required all zero",
               bcd, busy, valid, valid_pulse, err_out, blank);
    end
    @(negedge clk);
    rst = 1'b1;
    count_pulses(40, c);
    checks++;
    if (c !== 0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_abort: got pulses=%0d valid=%b busy=%b required 0 0 0", c, valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] ops[8];
    logic [4*DIGITS-1:0] exp_v;
    int lat, busy_n;
    logic vf;
    for (int i = 0; i < 8; i++) begin
      ops[i] = (i % 3 == 0) ? WIDTH'($urandom_range(0, 9999)) : $urandom;
      exp_q.push_back(model_bcd(ops[i]));
    end
    for (int i = 0; i < 8; i++) begin
      launch(ops[i], 1'b0);
      wait_pulse(1, lat, busy_n, vf);
      exp_v = exp_q.pop_front();
      checks++;
      if (lat !== WIDTH + 1 || vf !== 1'b0) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: got lat=%0d valid_at_capture=%b required %0d 0", i, lat, vf, WIDTH + 1);
      end
      checks++;
      if (bcd !== exp_v || blank !== model_blank(ops[i])) begin
        errors++;
        $display("FAIL b2b_bcd[%0d]: op=%h got bcd=%h blank=%b required %h %b",
                 i, ops[i], bcd, blank, exp_v, model_blank(ops[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_error();
    test_held_done();
    test_restart();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
